// File: rtl/mem_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the memory port arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_PROG, OWN_DATA, OWN_FETCH} owner_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] FULL_BE = 4'hF;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Requester and memory-side bundle; master = arbiter view.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          prog_ena;
  logic          p_req;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          p_ack;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic [3:0]    mem_en;
  logic          mem_wea;
  logic          mem_rea;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          mem_hold;

  modport master (
    input  prog_ena, p_req, p_addr, p_wdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  i_req, i_addr, mem_dout,
    output p_ack, d_rdata, d_ack, i_rdata, i_ack,
    output mem_en, mem_wea, mem_rea, mem_addr, mem_din, mem_hold
  );

  modport slave (
    output prog_ena, p_req, p_addr, p_wdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output i_req, i_addr, mem_dout,
    input  p_ack, d_rdata, d_ack, i_rdata, i_ack,
    input  mem_en, mem_wea, mem_rea, mem_addr, mem_din, mem_hold
  );
endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : Combinational winner select with fetch anti-starvation.
// Revision : 1.0
// ============================================================================
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CW         = 3
) (
  input  logic          i_prog_ena,
  input  logic          i_p_req,
  input  logic          i_d_req,
  input  logic          i_i_req,
  input  logic [CW-1:0] i_starve_cnt,
  output logic [2:0]    o_grant,
  output logic [CW-1:0] o_starve_nxt
);
  localparam logic [2:0]    c_gnt_prog  = 3'b001;
  localparam logic [2:0]    c_gnt_data  = 3'b010;
  localparam logic [2:0]    c_gnt_fetch = 3'b100;
  localparam logic [CW-1:0] c_starve_max = CW'(STARVE_MAX);

  always_comb begin
    o_grant      = 3'b000;
    o_starve_nxt = i_starve_cnt;
    if (i_prog_ena) begin
      if (i_p_req) o_grant = c_gnt_prog;
    end else if (i_d_req && i_i_req) begin
      // fetch only counts as losing when data actually beats it
      if (i_starve_cnt == c_starve_max) begin
        o_grant      = c_gnt_fetch;
        o_starve_nxt = '0;
      end else begin
        o_grant      = c_gnt_data;
        o_starve_nxt = i_starve_cnt + CW'(1);
      end
    end else if (i_d_req) begin
      o_grant = c_gnt_data;
    end else if (i_i_req) begin
      o_grant      = c_gnt_fetch;
      o_starve_nxt = '0;
    end
  end
endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between programmer, data and fetch.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               Rst,
  mem_port_arbiter_if.master bus
);
  localparam int         CW          = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [1:0] ST_IDLE     = S_IDLE;
  localparam logic [1:0] ST_ISSUE    = S_ISSUE;
  localparam logic [1:0] ST_WAIT     = S_WAIT;
  localparam logic [1:0] ST_RESP     = S_RESP;
  localparam logic [1:0] c_wait_last = 2'(RD_LAT - 1);

  logic [1:0]    r_state;
  owner_e        r_owner;
  logic [1:0]    r_wait;
  logic [CW-1:0] r_starve;
  logic [3:0]    r_mem_en;
  logic          r_mem_wea;
  logic          r_mem_rea;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_din;
  logic [DW-1:0] r_d_rdata;
  logic [DW-1:0] r_i_rdata;

  logic [2:0]    w_grant;
  logic [CW-1:0] w_starve_nxt;
  owner_e        w_owner;
  logic          w_we;
  logic [3:0]    w_be;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_resp;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX), .CW(CW)) u_pick (
    .i_prog_ena   (bus.prog_ena),
    .i_p_req      (bus.p_req),
    .i_d_req      (bus.d_req),
    .i_i_req      (bus.i_req),
    .i_starve_cnt (r_starve),
    .o_grant      (w_grant),
    .o_starve_nxt (w_starve_nxt)
  );

  // Reads always enable all lanes; only writes honour byte enables.
  always_comb begin
    w_owner = OWN_NONE;
    w_we    = 1'b0;
    w_be    = '0;
    w_addr  = '0;
    w_wdata = '0;
    if (w_grant[0]) begin
      w_owner = OWN_PROG;
      w_we    = 1'b1;
      w_be    = FULL_BE;
      w_addr  = bus.p_addr;
      w_wdata = bus.p_wdata;
    end else if (w_grant[1]) begin
      w_owner = OWN_DATA;
      w_we    = bus.d_we;
      w_be    = bus.d_we ? bus.d_be : FULL_BE;
      w_addr  = bus.d_addr;
      w_wdata = bus.d_wdata;
    end else if (w_grant[2]) begin
      w_owner = OWN_FETCH;
      w_be    = FULL_BE;
      w_addr  = bus.i_addr;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_NONE;
      r_wait     <= '0;
      r_starve   <= '0;
      r_mem_en   <= '0;
      r_mem_wea  <= 1'b0;
      r_mem_rea  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_d_rdata  <= '0;
      r_i_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_owner    <= w_owner;
            r_starve   <= w_starve_nxt;
            r_mem_en   <= w_be;
            r_mem_wea  <= w_we & (|w_be);
            r_mem_rea  <= ~w_we;
            r_mem_addr <= w_addr;
            r_mem_din  <= w_we ? w_wdata : '0;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mem_en   <= '0;
          r_mem_wea  <= 1'b0;
          r_mem_rea  <= 1'b0;
          r_mem_addr <= '0;
          r_mem_din  <= '0;
          r_wait     <= '0;
          r_state    <= r_mem_rea ? ST_WAIT : ST_RESP;
        end
        ST_WAIT: begin
          if (r_wait == c_wait_last) begin
            if (r_owner == OWN_DATA)  r_d_rdata <= bus.mem_dout;
            if (r_owner == OWN_FETCH) r_i_rdata <= bus.mem_dout;
            r_state <= ST_RESP;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_resp       = (r_state == ST_RESP);
  assign bus.p_ack    = w_resp && (r_owner == OWN_PROG);
  assign bus.d_ack    = w_resp && (r_owner == OWN_DATA);
  assign bus.i_ack    = w_resp && (r_owner == OWN_FETCH);
  assign bus.d_rdata  = r_d_rdata;
  assign bus.i_rdata  = r_i_rdata;
  assign bus.mem_en   = r_mem_en;
  assign bus.mem_wea  = r_mem_wea;
  assign bus.mem_rea  = r_mem_rea;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_din  = r_mem_din;
  // Reset gates the freeze so a held data request cannot stall a core in reset.
  assign bus.mem_hold = Rst & bus.d_req & ~bus.d_ack;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Randomized self-checking bench against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RD_LAT = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic Rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int mode = 0;             // 0 drop after ack, 1 always re-present, 2 random
  logic [31:0] ref_mem [16];
  logic [31:0] env_mem [16];
  logic [31:0] pipe [RD_LAT];
  logic        s_wea, s_rea;
  logic [3:0]  s_en;
  logic [31:0] s_addr, s_din;
  int          ackq[$];

  // transaction model state
  bit          m_busy;
  int          m_issue, m_resp, m_owner, m_lost;
  logic [3:0]  m_en;
  logic        m_wea, m_rea;
  logic [31:0] m_addr, m_din, m_rdata;
  logic [3:0]  e_en;
  logic        e_wea, e_rea, e_pack, e_dack, e_iack;
  logic [31:0] e_addr, e_din;
  logic        pv_pack, pv_dack, pv_iack;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic bit keep_req();
    if (mode == 1) return 1'b1;
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b0;
  endfunction

  task automatic new_p();
    bus.p_req = 1'b1; bus.p_addr = $urandom; bus.p_wdata = $urandom;
  endtask
  task automatic new_d();
    bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
    bus.d_be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    bus.d_addr = $urandom; bus.d_wdata = $urandom;
  endtask
  task automatic new_i();
    bus.i_req = 1'b1; bus.i_addr = $urandom;
  endtask

  task automatic update_reqs();
    if (mode == 2) begin
      if (!bus.prog_ena && $urandom_range(0, 99) == 0) bus.prog_ena = 1'b1;
      else if (bus.prog_ena && $urandom_range(0, 15) == 0) bus.prog_ena = 1'b0;
    end
    if (bus.p_req && pv_pack) begin if (keep_req()) new_p(); else bus.p_req = 1'b0; end
    else if (!bus.p_req && mode == 2 && $urandom_range(0, 2) == 0) new_p();
    if (bus.d_req && pv_dack) begin if (keep_req()) new_d(); else bus.d_req = 1'b0; end
    else if (!bus.d_req && mode == 2 && $urandom_range(0, 2) == 0) new_d();
    if (bus.i_req && pv_iack) begin if (keep_req()) new_i(); else bus.i_req = 1'b0; end
    else if (!bus.i_req && mode == 2 && $urandom_range(0, 2) == 0) new_i();
  endtask

  // Spec rules: who wins, when ISSUE and RESP happen, what memory holds.
  task automatic model_step();
    int who; logic we; logic [3:0] be; logic [31:0] a, w;
    e_en = '0; e_wea = 0; e_rea = 0; e_addr = '0; e_din = '0;
    e_pack = 0; e_dack = 0; e_iack = 0;
    if (m_busy && cyc > m_resp) m_busy = 0;
    if (!m_busy) begin
      who = 0; we = 0; be = FULL_BE; a = '0; w = '0;
      if (bus.prog_ena) begin
        if (bus.p_req) who = 1;
      end else if (bus.d_req && bus.i_req) begin
        if (m_lost == STARVE_MAX) who = 3;
        else begin who = 2; m_lost++; end
      end else if (bus.d_req) who = 2;
      else if (bus.i_req) who = 3;
      if (who == 3) m_lost = 0;
      if (who == 1) begin we = 1; a = bus.p_addr; w = bus.p_wdata; end
      if (who == 2) begin we = bus.d_we; be = bus.d_we ? bus.d_be : FULL_BE; a = bus.d_addr; w = bus.d_wdata; end
      if (who == 3) a = bus.i_addr;
      if (who != 0) begin
        m_busy = 1; m_owner = who; m_issue = cyc + 1;
        m_resp = cyc + 2 + (we ? 0 : RD_LAT);
        m_en = be; m_wea = we && (be != 0); m_rea = !we; m_addr = a; m_din = we ? w : '0;
        if (we) begin
          for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a[5:2]][8*b +: 8] = w[8*b +: 8];
        end else m_rdata = ref_mem[a[5:2]];
      end
    end else begin
      if (cyc == m_issue) begin
        e_en = m_en; e_wea = m_wea; e_rea = m_rea; e_addr = m_addr; e_din = m_din;
      end
      if (cyc == m_resp) begin
        e_pack = (m_owner == 1); e_dack = (m_owner == 2); e_iack = (m_owner == 3);
      end
    end
  endtask

  task automatic compare();
    chk("mem_en", 32'(bus.mem_en), 32'(e_en));
    chk("mem_wea", 32'(bus.mem_wea), 32'(e_wea));
    chk("mem_rea", 32'(bus.mem_rea), 32'(e_rea));
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_din", bus.mem_din, e_din);
    chk("p_ack", 32'(bus.p_ack), 32'(e_pack));
    chk("d_ack", 32'(bus.d_ack), 32'(e_dack));
    chk("i_ack", 32'(bus.i_ack), 32'(e_iack));
    chk("mem_hold", 32'(bus.mem_hold), 32'(bus.d_req & ~e_dack));
    if (e_dack && m_rea) chk("d_rdata", bus.d_rdata, m_rdata);
    if (e_iack) chk("i_rdata", bus.i_rdata, m_rdata);
    if (bus.d_ack) ackq.push_back(2);
    if (bus.i_ack) ackq.push_back(3);
    s_wea = bus.mem_wea; s_rea = bus.mem_rea; s_en = bus.mem_en;
    s_addr = bus.mem_addr; s_din = bus.mem_din;
    pv_pack = e_pack; pv_dack = e_dack; pv_iack = e_iack;
  endtask

  // Entered and left at posedge+1; memory reacts to last cycle's port values.
  task automatic run_cycle();
    if (s_wea)
      for (int b = 0; b < 4; b++) if (s_en[b]) env_mem[s_addr[5:2]][8*b +: 8] = s_din[8*b +: 8];
    for (int k = RD_LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = s_rea ? env_mem[s_addr[5:2]] : $urandom;
    bus.mem_dout = pipe[RD_LAT-1];
    update_reqs();
    model_step();
    @(negedge clk);
    compare();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'h0);
    chk({tag, "_mem_wea"}, 32'(bus.mem_wea), 32'h0);
    chk({tag, "_mem_rea"}, 32'(bus.mem_rea), 32'h0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_acks"}, 32'({bus.p_ack, bus.d_ack, bus.i_ack}), 32'h0);
    chk({tag, "_mem_hold"}, 32'(bus.mem_hold), 32'h0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
    chk({tag, "_i_rdata"}, bus.i_rdata, 32'h0);
  endtask

  task automatic clear_model();
    m_busy = 0; m_lost = 0;
    s_wea = 0; s_rea = 0; s_en = '0; s_addr = '0; s_din = '0;
    pv_pack = 0; pv_dack = 0; pv_iack = 0;
  endtask

  initial begin
    int exp_ord [10] = '{2, 2, 2, 2, 3, 2, 2, 2, 2, 3};
    int guard, acks_before;
    Rst = 1'b0;
    for (int k = 0; k < 16; k++) begin ref_mem[k] = $urandom; env_mem[k] = ref_mem[k]; end
    for (int k = 0; k < RD_LAT; k++) pipe[k] = '0;
    bus.mem_dout = '0; bus.prog_ena = 1'b0;
    bus.p_req = 0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.i_req = 0; bus.i_addr = '0;
    clear_model();
    new_d(); new_i();
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("rst");
    @(posedge clk); #1 Rst = 1'b1;

    // data and fetch both held: four data grants then a forced fetch
    mode = 1;
    guard = 0;
    while (ackq.size() < 10 && guard < 200) begin run_cycle(); guard++; end
    for (int k = 0; k < 10; k++) chk("grant_order", (k < ackq.size()) ? ackq[k] : 0, exp_ord[k]);

    mode = 2;
    repeat (3000) run_cycle();

    // drain, then reset in the middle of a data read's WAIT
    mode = 0; bus.prog_ena = 1'b0; bus.p_req = 1'b0;
    guard = 0;
    while ((bus.d_req || bus.i_req || (m_busy && cyc <= m_resp)) && guard < 100) begin
      run_cycle(); guard++;
    end
    chk("drain_done", 32'(bus.d_req | bus.i_req), 32'h0);
    new_d(); bus.d_we = 1'b0;
    run_cycle(); run_cycle();
    #2 Rst = 1'b0;
    #1 check_reset_outputs("rst_wait");
    @(posedge clk); #1 Rst = 1'b1;
    clear_model(); cyc++;
    acks_before = ackq.size();
    repeat (10) run_cycle();
    chk("reissue_acks", ackq.size() - acks_before, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single external memory port (mem_en/mem_wea/mem_addr/mem_din/mem_dout) between three requesters: the UART programmer write stream, the Memory-stage data port, and the Fetch instruction port. It sequences each access through a fixed issue/wait/respond state machine, with registered memory-side outputs. It generates mem_hold to freeze the pipeline while a data access is outstanding. It sits between the core and the memory controller, replacing direct wiring of separate imem and dmem ports.

Parameters:
AW, 32, address width
DW, 32, data width
RD_LAT, 1, memory read latency in cycles (mem_dout valid RD_LAT cycles after the mem_en cycle); legal range 1..4
STARVE_MAX, 4, consecutive lost arbitrations after which fetch is forced to win

Ports:
clk  in  1  system clock
Rst  in  1  reset, asynchronous, active-low
prog_ena  in  1  programmer mode; only the programmer is served
p_req  in  1  programmer write request
p_addr  in  AW  programmer address
p_wdata  in  DW  programmer data
p_ack  out  1  programmer write done pulse
d_req  in  1  data request
d_we  in  1  data write (1) / read (0)
d_be  in  4  data byte enables
d_addr  in  AW  data address
d_wdata  in  DW  data write data
d_rdata  out  DW  data read result, valid while d_ack=1
d_ack  out  1  data done pulse
i_req  in  1  fetch request (read only)
i_addr  in  AW  fetch address
i_rdata  out  DW  instruction, valid while i_ack=1
i_ack  out  1  fetch done pulse
mem_en  out  4  byte enables to memory
mem_wea  out  1  memory write strobe
mem_rea  out  1  memory read strobe
mem_addr  out  AW  memory address
mem_din  out  DW  memory write data
mem_dout  in  DW  memory read data
mem_hold  out  1  pipeline freeze

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE; starve counter 0; all outputs 0; rdata registers 0.
- Requesters hold req, addr, and data stable until ack. Each ack is a single-cycle pulse; the requester may drop or re-present req in the following cycle.
- States:
  - IDLE: arbitrate; on a winner, latch owner and request fields and go to ISSUE.
  - ISSUE (1 cycle): drive the mem_* outputs from registers. Writes use mem_wea=1, mem_en=be (p: 4'hF). Reads use mem_rea=1, mem_en=4'hF. Writes go to RESP; reads go to WAIT.
  - WAIT: count RD_LAT cycles. In the last cycle, capture mem_dout into the owner's rdata register, then go to RESP.
  - RESP (1 cycle): pulse the owner's ack; rdata is stable; go to IDLE.
- Latency from req seen in IDLE to ack: writes 2 cycles, reads 2+RD_LAT cycles. Minimum throughput is one transaction per 3 cycles (writes) or 3+RD_LAT cycles (reads).
- Arbitration in IDLE:
  - prog_ena=1: only p_req is eligible; d_req and i_req wait.
  - prog_ena=0: p_req is ignored. d_req beats i_req unless starve_cnt==STARVE_MAX, in which case i_req wins.
  - starve_cnt increments (saturating at STARVE_MAX) when i_req loses to d_req, and clears on a fetch grant.
- mem_* outputs are 0 in every state except ISSUE. mem_din is 0 on reads.
- Write with d_be=0: full sequence runs and d_ack is pulsed; mem_en=0 and mem_wea=0 (no memory write).
- mem_hold = d_req & ~d_ack (combinational). It is 0 in reset.
- prog_ena changing mid-transaction: the current transaction completes normally; the new mode applies at the next IDLE arbitration.
- A req deasserted before its ack is a protocol violation; the transaction still completes and the ack is still pulsed.
- Addresses pass through unmodified; no alignment checks.

Decomposition:
- Package mem_arb_pkg:
  - owner_e enum {OWN_NONE, OWN_PROG, OWN_DATA, OWN_FETCH}
  - state_e enum {S_IDLE, S_ISSUE, S_WAIT, S_RESP}
  - localparam FULL_BE = 4'hF
- Sub-module mem_arb_pick: combinational priority/starvation winner select. Inputs: prog_ena, the three reqs, starve_cnt. Outputs: a one-hot grant plus the next starve_cnt. The FSM, datapath registers, and outputs stay in the top module.

Test Plan:
- Data write: d_req=1, d_we=1, d_be=4'h3, d_addr=32'h100, d_wdata=32'hDEADBEEF → ISSUE cycle shows mem_wea=1, mem_en=4'h3, mem_addr=32'h100; d_ack exactly 2 cycles after d_req; mem_hold=1 for those 2 cycles.
- Fetch read, RD_LAT=2: memory returns 32'h00000013 → i_ack at cycle 4 with i_rdata=32'h00000013; mem_rea=1 only in ISSUE.
- Simultaneous: d_req and i_req held continuously, STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I; starve_cnt resets to 0 after each I.
- prog_ena=1 with p_req, d_req, i_req all high → only programmer writes issue (mem_en=4'hF); d_ack/i_ack stay 0 and mem_hold stays 1. Drop prog_ena → data is served next.
- Rst pulled low during WAIT → all outputs 0 immediately with no ack. After release, the held request reissues from IDLE and completes normally.
- Write with d_be=0 → d_ack after 2 cycles; mem_wea=0 and mem_en=0 throughout.
